// File: rtl/hex_console_display.sv
// ---------------------------------------------------------------------------
// hex_console_display
//
// Character sink for the CPU console stream. ASCII hex characters are shifted
// into a 32-bit display word (newest character on the rightmost digit), a
// newline clears the word, every other byte is ignored. The word is scanned
// continuously onto an 8-digit multiplexed 7-segment display.
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   enable        display enable; low blanks all anodes (parsing continues)
//   out_byte      character written by the CPU
//   out_byte_en   single-cycle write strobe qualifying out_byte
//   cathode_array {dp,g,f,e,d,c,b,a}, active low, registered
//   anode_array   one-hot-low digit select, registered
//   digit_count   valid digits since last clear, saturates at NUM_DIGITS
//
// Write handshake: out_byte is consumed on every rising clk edge where
// out_byte_en is high. There is no ready/backpressure; the sink accepts one
// byte per cycle unconditionally, so back-to-back strobes are all taken.
// ---------------------------------------------------------------------------
module hex_console_display #(
    parameter int REFRESH_DIV = 1000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] out_byte,
    input  logic       out_byte_en,
    output logic [7:0] cathode_array,
    output logic [7:0] anode_array,
    output logic [3:0] digit_count
);

    localparam int CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDXW = $clog2(NUM_DIGITS);

    logic [31:0]     disp_word;
    logic [CW-1:0]   refresh_cnt;
    logic [IDXW-1:0] digit_idx;

    logic            is_hex;
    logic [3:0]      nibble;
    logic [3:0]      sel_nibble;
    logic [6:0]      seg_bits;

    // ASCII hex decode. Letters 'A'-'F' / 'a'-'f' have low nibble 1..6, so
    // adding 9 yields 10..15.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (out_byte >= 8'h30 && out_byte <= 8'h39) begin
            is_hex = 1'b1;
            nibble = out_byte[3:0];
        end else if ((out_byte >= 8'h41 && out_byte <= 8'h46) ||
                     (out_byte >= 8'h61 && out_byte <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = out_byte[3:0] + 4'd9;
        end
    end

    // Display word and digit count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp_word   <= 32'h0;
            digit_count <= 4'd0;
        end else if (out_byte_en) begin
            if (is_hex) begin
                disp_word <= {disp_word[27:0], nibble};
                if (digit_count != 4'(NUM_DIGITS))
                    digit_count <= digit_count + 4'd1;
            end else if (out_byte == 8'h0A) begin
                disp_word   <= 32'h0;
                digit_count <= 4'd0;
            end
        end
    end

    // Refresh timing: each digit is held for REFRESH_DIV cycles. The index
    // wraps naturally because NUM_DIGITS is a power of two. Runs regardless
    // of enable so the scan phase is independent of blanking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign sel_nibble = disp_word[{digit_idx, 2'b00} +: 4];

    // Segment patterns {g,f,e,d,c,b,a}, active low.
    always_comb begin
        seg_bits = 7'h7F;
        case (sel_nibble)
            4'h0: seg_bits = 7'h40;
            4'h1: seg_bits = 7'h79;
            4'h2: seg_bits = 7'h24;
            4'h3: seg_bits = 7'h30;
            4'h4: seg_bits = 7'h19;
            4'h5: seg_bits = 7'h12;
            4'h6: seg_bits = 7'h02;
            4'h7: seg_bits = 7'h78;
            4'h8: seg_bits = 7'h00;
            4'h9: seg_bits = 7'h10;
            4'hA: seg_bits = 7'h08;
            4'hB: seg_bits = 7'h03;
            4'hC: seg_bits = 7'h46;
            4'hD: seg_bits = 7'h21;
            4'hE: seg_bits = 7'h06;
            4'hF: seg_bits = 7'h0E;
            default: seg_bits = 7'h7F;
        endcase
    end

    // Registered outputs, one cycle behind index/data. Digits at or above
    // digit_count are blanked so unwritten leading positions stay dark.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            anode_array   <= 8'hFF;
            cathode_array <= 8'hFF;
        end else begin
            anode_array   <= enable ? ~(8'b0000_0001 << digit_idx) : 8'hFF;
            cathode_array <= ({1'b0, digit_idx} < digit_count) ?
                             {1'b1, seg_bits} : 8'hFF;
        end
    end

endmodule

// File: tb/tb_hex_console_display.sv
module tb_hex_console_display;

    localparam int RD = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] out_byte = 8'h00;
    logic       out_byte_en = 1'b0;
    logic [7:0] cathode_array;
    logic [7:0] anode_array;
    logic [3:0] digit_count;

    int checks = 0;
    int errors = 0;

    // Reference model: characters on screen as a list, oldest first.
    logic [3:0] exp_q[$];
    logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int         n = 0;          // rising edges since reset release
    logic [7:0] exp_anode;
    logic [7:0] exp_cathode;
    logic [3:0] exp_count;

    hex_console_display #(.REFRESH_DIV(RD), .NUM_DIGITS(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .out_byte      (out_byte),
        .out_byte_en   (out_byte_en),
        .cathode_array (cathode_array),
        .anode_array   (anode_array),
        .digit_count   (digit_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver / model ----------------
    // Advance one clock. Outputs seen at the following falling edge reflect
    // the digit selected and the text on screen before this edge; the count
    // reflects the byte written on this edge.
    task automatic tick();
        logic [7:0] b;
        logic       e;
        logic       en;
        int         idx;
        logic [7:0] one;
        b  = out_byte;
        e  = out_byte_en;
        en = enable;
        one = 8'b0000_0001;
        @(posedge clk);
        n++;
        @(negedge clk);
        idx = ((n - 1) / RD) % 8;
        exp_anode = en ? ~(one << idx) : 8'hFF;
        if (idx < exp_q.size())
            exp_cathode = seg_tab[exp_q[exp_q.size() - 1 - idx]];
        else
            exp_cathode = 8'hFF;
        if (e) begin
            if (b >= "0" && b <= "9") exp_q.push_back(4'(b - 8'h30));
            else if (b >= "A" && b <= "F") exp_q.push_back(4'(b - 8'h41 + 10));
            else if (b >= "a" && b <= "f") exp_q.push_back(4'(b - 8'h61 + 10));
            else if (b == 8'h0A) exp_q.delete();
            if (exp_q.size() > 8) void'(exp_q.pop_front());
        end
        exp_count = 4'(exp_q.size());
    endtask

    task automatic put(input logic [7:0] b);
        out_byte    = b;
        out_byte_en = 1'b1;
        tick();
        out_byte_en = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        int v;
        r = $urandom_range(0, 9);
        v = $urandom_range(0, 15);
        if (r <= 5) begin
            if (v < 10) return 8'(8'h30 + v);
            return ($urandom_range(0, 1) != 0) ? 8'(8'h41 + v - 10) : 8'(8'h61 + v - 10);
        end
        if (r == 6) return 8'h0A;
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        enable = 1'b1;
        out_byte_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (anode_array !== 8'hFF || cathode_array !== 8'hFF || digit_count !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold: got an=%h ca=%h cnt=%0d expected an=FF ca=FF cnt=0",
                         anode_array, cathode_array, digit_count);
            end
        end
        resetn = 1'b1;
        n = 0;
        exp_q.delete();
    endtask

    task automatic test_idle_scan();
        enable = 1'b1;
        for (int i = 0; i < 8 * RD + 5; i++) begin
            tick();
            checks += 3;
            if (anode_array !== exp_anode) begin
                errors++; $display("FAIL idle_anode: got %h expected %h", anode_array, exp_anode);
            end
            if (cathode_array !== 8'hFF) begin
                errors++; $display("FAIL idle_cathode: got %h expected FF", cathode_array);
            end
            if (digit_count !== 4'd0) begin
                errors++; $display("FAIL idle_count: got %0d expected 0", digit_count);
            end
        end
    endtask

    task automatic test_two_chars();
        put(8'h31);
        put(8'h41);
        checks++;
        if (digit_count !== 4'd2) begin
            errors++; $display("FAIL two_count: got %0d expected 2", digit_count);
        end
        for (int i = 0; i < 8 * RD + 2; i++) begin
            tick();
            checks += 3;
            if (anode_array !== exp_anode) begin
                errors++; $display("FAIL two_anode: got %h expected %h", anode_array, exp_anode);
            end
            if (cathode_array !== exp_cathode) begin
                errors++; $display("FAIL two_cathode: got %h expected %h (an=%h)", cathode_array, exp_cathode, anode_array);
            end
            if (digit_count !== exp_count) begin
                errors++; $display("FAIL two_count_scan: got %0d expected %0d", digit_count, exp_count);
            end
        end
    endtask

    task automatic test_nine_chars();
        put(8'h0A);
        for (int c = 1; c <= 9; c++) put(8'(8'h30 + c));
        checks++;
        if (digit_count !== 4'd8) begin
            errors++; $display("FAIL nine_count: got %0d expected 8", digit_count);
        end
        for (int i = 0; i < 8 * RD + 2; i++) begin
            tick();
            checks += 3;
            if (anode_array !== exp_anode) begin
                errors++; $display("FAIL nine_anode: got %h expected %h", anode_array, exp_anode);
            end
            if (cathode_array !== exp_cathode) begin
                errors++; $display("FAIL nine_cathode: got %h expected %h (an=%h)", cathode_array, exp_cathode, anode_array);
            end
            if (digit_count !== exp_count) begin
                errors++; $display("FAIL nine_count_scan: got %0d expected %0d", digit_count, exp_count);
            end
        end
    endtask

    task automatic test_ignore_and_clear();
        put(8'h0A);
        put(8'h66);
        checks++;
        if (digit_count !== 4'd1) begin
            errors++; $display("FAIL ign_count_f: got %0d expected 1", digit_count);
        end
        put(8'h47);
        checks++;
        if (digit_count !== 4'd1) begin
            errors++; $display("FAIL ign_count_G: got %0d expected 1", digit_count);
        end
        // let digit 0 come round while 'f' is on screen
        for (int i = 0; i < 8 * RD + 2; i++) begin
            tick();
            checks++;
            if (cathode_array !== exp_cathode) begin
                errors++; $display("FAIL ign_cathode: got %h expected %h (an=%h)", cathode_array, exp_cathode, anode_array);
            end
        end
        put(8'h0A);
        checks++;
        if (digit_count !== 4'd0) begin
            errors++; $display("FAIL clr_count: got %0d expected 0", digit_count);
        end
        for (int i = 0; i < 8 * RD + 2; i++) begin
            tick();
            checks++;
            if (cathode_array !== exp_cathode) begin
                errors++; $display("FAIL clr_cathode: got %h expected %h", cathode_array, exp_cathode);
            end
        end
    endtask

    task automatic test_enable_low();
        enable = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (i == 200) put(8'h45);
            else tick();
            checks += 2;
            if (anode_array !== 8'hFF) begin
                errors++; $display("FAIL en_low_anode: got %h expected FF", anode_array);
            end
            if (digit_count !== exp_count) begin
                errors++; $display("FAIL en_low_count: got %0d expected %0d", digit_count, exp_count);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 8 * RD + 2; i++) begin
            tick();
            checks += 2;
            if (anode_array !== exp_anode) begin
                errors++; $display("FAIL en_high_anode: got %h expected %h", anode_array, exp_anode);
            end
            if (cathode_array !== exp_cathode) begin
                errors++; $display("FAIL en_high_cathode: got %h expected %h", cathode_array, exp_cathode);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            out_byte    = rand_byte();
            out_byte_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            tick();
            checks += 3;
            if (anode_array !== exp_anode) begin
                errors++; $display("FAIL b2b_anode: got %h expected %h", anode_array, exp_anode);
            end
            if (cathode_array !== exp_cathode) begin
                errors++; $display("FAIL b2b_cathode: got %h expected %h", cathode_array, exp_cathode);
            end
            if (digit_count !== exp_count) begin
                errors++; $display("FAIL b2b_count: got %0d expected %0d", digit_count, exp_count);
            end
        end
        out_byte_en = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_scan();
        int guard;
        put(8'h33);
        put(8'h37);
        guard = 0;
        while (((n / RD) % 8) != 5 && guard < 8 * RD + 1) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 8 * RD + 1) begin
            errors++; $display("FAIL mid_scan_reach: got no index 5 within %0d cycles expected reach", guard);
        end
        out_byte    = 8'h39;
        out_byte_en = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (anode_array !== 8'hFF || cathode_array !== 8'hFF || digit_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got an=%h ca=%h cnt=%0d expected an=FF ca=FF cnt=0",
                     anode_array, cathode_array, digit_count);
        end
        @(negedge clk);
        out_byte_en = 1'b0;
        @(negedge clk);
        checks++;
        if (anode_array !== 8'hFF || cathode_array !== 8'hFF || digit_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_hold: got an=%h ca=%h cnt=%0d expected an=FF ca=FF cnt=0",
                     anode_array, cathode_array, digit_count);
        end
        resetn = 1'b1;
        n = 0;
        exp_q.delete();
        for (int i = 0; i < 2 * RD + 2; i++) begin
            tick();
            checks += 3;
            if (anode_array !== exp_anode) begin
                errors++; $display("FAIL post_reset_anode: got %h expected %h", anode_array, exp_anode);
            end
            if (cathode_array !== 8'hFF) begin
                errors++; $display("FAIL post_reset_cathode: got %h expected FF", cathode_array);
            end
            if (digit_count !== 4'd0) begin
                errors++; $display("FAIL post_reset_count: got %0d expected 0", digit_count);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle_scan();
        test_two_chars();
        test_nine_chars();
        test_ignore_and_clear();
        test_enable_low();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
